// File: rtl/ysyx_24110015_lsu.sv
// ysyx_24110015_lsu: multi-cycle load/store unit on a req/gnt/rvalid bus with byte strobes and timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of silently aligning them down.
module ysyx_24110015_lsu #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_wen,
    input  logic [2:0]      in_func3,
    input  logic [AW-1:0]   in_addr,
    input  logic [DW-1:0]   in_wdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_rdata,
    output logic            out_err,
    output logic            mem_req,
    input  logic            mem_gnt,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_rerr
);
    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);
    localparam int SW = $clog2(DW) + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [2:0]      func3_q, func3_d;
    logic            wen_q, wen_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [OW-1:0]   in_off, in_am, off;
    logic [1:0]      sz;
    logic            illegal, bad, tmo;
    logic [SW-1:0]   k;
    logic [DW-1:0]   sh, sl, ext;
    logic signed [DW-1:0] sx;

    assign in_off  = in_addr[OW-1:0];
    assign in_am   = OW'((4'd1 << in_func3[1:0]) - 4'd1);
    assign illegal = (in_func3 == 3'b111) || (in_wen && in_func3[2]) ||
                     (DW == 32 && (in_func3[1:0] == 2'b11 || in_func3 == 3'b110));
`ifdef LSU_MISALIGN_TRAP_EN
    assign bad = illegal || |(in_off & in_am);
`else
    assign bad = illegal;
`endif

    // Extension: move the selected lanes to the top, then shift back arithmetically or logically.
    assign off = addr_q[OW-1:0];
    assign sz  = func3_q[1:0];
    assign k   = SW'(DW) - (SW'(8) << sz);
    assign sh  = mem_rdata >> {off, 3'b000};
    assign sl  = sh << k;
    assign sx  = $signed(sl) >>> k;
    assign ext = func3_q[2] ? sl >> k : $unsigned(sx);
    assign tmo = cnt_q == CW'(TIMEOUT - 1);

    assign in_ready  = state_q == IDLE && !rst;
    assign out_valid = state_q == RESP;
    assign out_rdata = rdata_q;
    assign out_err   = err_q;
    assign mem_req   = state_q == REQ;
    assign mem_we    = mem_req && wen_q;
    assign mem_addr  = mem_req ? {addr_q[AW-1:OW], {OW{1'b0}}} : '0;
    assign mem_wdata = mem_req ? wdata_q << {off, 3'b000} : '0;
    assign mem_wstrb = mem_req ? ~({NB{1'b1}} << (4'd1 << sz)) << off : '0;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        func3_d = func3_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                addr_d  = {in_addr[AW-1:OW], in_off & ~in_am};
                func3_d = in_func3;
                wen_d   = in_wen;
                wdata_d = in_wdata;
                rdata_d = '0;
                err_d   = bad;
                cnt_d   = '0;
                state_d = bad ? RESP : REQ;
            end
            REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (tmo) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_rvalid) begin
                    rdata_d = (wen_q || mem_rerr) ? '0 : ext;
                    err_d   = mem_rerr;
                    state_d = RESP;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP: if (out_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            func3_q <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            func3_q <= func3_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ysyx_24110015_lsu.sv
// tb_ysyx_24110015_lsu: scoreboard bench for the LSU, a DW=32 instance and a DW=64 instance, both TIMEOUT=4.
module tb_ysyx_24110015_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        v = 0, rdy, wen = 0, ov, ordy = 1, oerr;
    logic [2:0]  f3 = 0;
    logic [31:0] addr = 0, wdata = 0, ordata;
    logic        mreq, mgnt = 0, mwe, mrv = 0, mrerr = 0;
    logic [31:0] maddr, mwdata, mrdata = 0;
    logic [3:0]  mwstrb;

    logic        d_v = 0, d_rdy, d_ov, d_oerr, d_req, d_gnt = 0, d_we, d_rv = 0, d_rerr = 0;
    logic [2:0]  d_f3 = 0;
    logic [31:0] d_addr = 0, d_maddr;
    logic [63:0] d_ordata, d_mwdata, d_rdata = 64'hF123456789ABCDEF;
    logic [7:0]  d_wstrb;

    ysyx_24110015_lsu #(.DW(32), .AW(32), .TIMEOUT(4)) u32 (
        .clk(clk), .rst(rst), .in_valid(v), .in_ready(rdy), .in_wen(wen), .in_func3(f3),
        .in_addr(addr), .in_wdata(wdata), .out_valid(ov), .out_ready(ordy), .out_rdata(ordata),
        .out_err(oerr), .mem_req(mreq), .mem_gnt(mgnt), .mem_we(mwe), .mem_addr(maddr),
        .mem_wdata(mwdata), .mem_wstrb(mwstrb), .mem_rvalid(mrv), .mem_rdata(mrdata), .mem_rerr(mrerr)
    );

    ysyx_24110015_lsu #(.DW(64), .AW(32), .TIMEOUT(4)) u64 (
        .clk(clk), .rst(rst), .in_valid(d_v), .in_ready(d_rdy), .in_wen(1'b0), .in_func3(d_f3),
        .in_addr(d_addr), .in_wdata(64'd0), .out_valid(d_ov), .out_ready(1'b1), .out_rdata(d_ordata),
        .out_err(d_oerr), .mem_req(d_req), .mem_gnt(d_gnt), .mem_we(d_we), .mem_addr(d_maddr),
        .mem_wdata(d_mwdata), .mem_wstrb(d_wstrb), .mem_rvalid(d_rv), .mem_rdata(d_rdata), .mem_rerr(d_rerr)
    );

    typedef struct { logic [63:0] rd; logic err; int acc; int lat; } exp_t;
    typedef struct { logic [31:0] a; logic we; logic [31:0] wd; logic [3:0] st; logic cs; } bus_t;
    exp_t q[$], q64[$];
    bus_t bq[$];

    int checks = 0, fails = 0;
    int reqcyc = 0;
    logic gnt_en = 1, rv_en = 1, stray = 0, pend = 0, bus_rerr = 0;
    logic [31:0] bus_rdata = 32'h80FF1234;
    logic d_pend = 0;
    logic [31:0] d_exp_addr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Bus slave for the 32-bit instance: grants when enabled, answers one cycle after the grant.
    always @(negedge clk) begin
        bus_t b;
        mrv   = (pend & rv_en) | stray;
        mrdata = bus_rdata;
        mrerr = bus_rerr;
        if (mreq) reqcyc++;
        mgnt = mreq & gnt_en;
        pend = mgnt;
        if (mgnt) begin
            if (bq.size() == 0) begin
                checks++; fails++;
                $display("FAIL bus_unexpected: request at %h, none expected", maddr);
            end else begin
                b = bq.pop_front();
                chk("mem_addr", maddr, b.a);
                chk("mem_we", mwe, b.we);
                chk("mem_wdata", mwdata, b.wd);
                if (b.cs) chk("mem_wstrb", mwstrb, b.st);
            end
        end
    end

    always @(negedge clk) begin
        d_rv   = d_pend;
        d_gnt  = d_req;
        d_pend = d_gnt;
        if (d_gnt) begin
            chk("d_mem_addr", d_maddr, d_exp_addr);
            chk("d_mem_we", d_we, 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ov) chk("in_ready_in_resp", rdy, 0);
        if (ov && ordy) begin
            if (q.size() == 0) begin
                checks++; fails++;
                $display("FAIL resp_unexpected: rdata %h err %b, none expected", ordata, oerr);
            end else begin
                e = q.pop_front();
                chk("out_rdata", ordata, e.rd);
                chk("out_err", oerr, e.err);
                if (e.lat >= 0) chk("latency", cyc - e.acc, e.lat);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (d_ov) begin
            if (q64.size() == 0) begin
                checks++; fails++;
                $display("FAIL d_resp_unexpected: rdata %h, none expected", d_ordata);
            end else begin
                e = q64.pop_front();
                chk("d_out_rdata", d_ordata, e.rd);
                chk("d_out_err", d_oerr, e.err);
                chk("d_latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                         input logic [63:0] er, input logic ee, input int lat, input logic push, output int acc);
        exp_t e;
        @(negedge clk);
        v = 1; wen = w; f3 = f; addr = a; wdata = wd;
        for (int i = 0; i < 100 && !rdy; i++) @(negedge clk);
        if (!rdy) begin
            checks++; fails++;
            $display("FAIL accept_timeout: in_ready %b, required 1", rdy);
        end
        acc = cyc;
        e.rd = er; e.err = ee; e.acc = acc; e.lat = lat;
        if (push) q.push_back(e);
        @(negedge clk);
        v = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || q64.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || q64.size() != 0) begin
            checks++; fails++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", q.size() + q64.size());
        end
        @(negedge clk);
    endtask

    task automatic run(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                       input logic bus, input logic [31:0] ba, input logic [31:0] bwd, input logic [3:0] bst,
                       input logic [31:0] er, input logic ee, input int lat);
        bus_t b;
        int acc, r0;
        b.a = ba; b.we = w; b.wd = bwd; b.st = bst; b.cs = w;
        if (bus) bq.push_back(b);
        r0 = reqcyc;
        issue(w, f, a, wd, {32'd0, er}, ee, lat, 1, acc);
        drain();
        if (!bus) chk("no_bus_access", reqcyc - r0, 0);
    endtask

    task automatic issue64(input logic [2:0] f, input logic [31:0] a, input logic [31:0] ea, input logic [63:0] er);
        exp_t e;
        d_exp_addr = ea;
        @(negedge clk);
        d_v = 1; d_f3 = f; d_addr = a;
        for (int i = 0; i < 100 && !d_rdy; i++) @(negedge clk);
        if (!d_rdy) begin
            checks++; fails++;
            $display("FAIL d_accept_timeout: in_ready %b, required 1", d_rdy);
        end
        e.rd = er; e.err = 0; e.acc = cyc; e.lat = 3;
        q64.push_back(e);
        @(negedge clk);
        d_v = 0;
        drain();
    endtask

    task automatic stray_pulse();
        @(posedge clk); #1 stray = 1;
        @(posedge clk); #1 stray = 0;
        repeat (3) begin
            @(negedge clk);
            chk("stray_ignored", ov, 0);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_out_valid"}, ov, 0);
        chk({tag, "_out_rdata"}, ordata, 0);
        chk({tag, "_out_err"}, oerr, 0);
        chk({tag, "_mem_req"}, mreq, 0);
        chk({tag, "_mem_we"}, mwe, 0);
        chk({tag, "_mem_addr"}, maddr, 0);
        chk({tag, "_mem_wdata"}, mwdata, 0);
        chk({tag, "_mem_wstrb"}, mwstrb, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_t b;
        int acc, acc2, rc, r0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", rdy, 0);
        chk("reset_d_in_ready", d_rdy, 0);
        chk("reset_d_out_valid", d_ov, 0);
        chk_idle_outputs("reset");
        rst = 0;
        @(negedge clk);
        chk("in_ready_after_reset", rdy, 1);

        run(0, 3'b000, 32'h80000003, 0, 1, 32'h80000000, 0, 0, 32'hFFFFFF80, 0, 3);
        run(0, 3'b100, 32'h80000003, 0, 1, 32'h80000000, 0, 0, 32'h00000080, 0, 3);
        run(0, 3'b001, 32'h80000002, 0, 1, 32'h80000000, 0, 0, 32'hFFFF80FF, 0, 3);
        run(0, 3'b101, 32'h80000002, 0, 1, 32'h80000000, 0, 0, 32'h000080FF, 0, 3);
        run(0, 3'b010, 32'h80000000, 0, 1, 32'h80000000, 0, 0, 32'h80FF1234, 0, 3);
        run(1, 3'b001, 32'h80000002, 32'h0000BEEF, 1, 32'h80000000, 32'hBEEF0000, 4'b1100, 0, 0, 3);
        run(1, 3'b000, 32'h80000001, 32'h000000A5, 1, 32'h80000000, 32'h0000A500, 4'b0010, 0, 0, 3);
        run(1, 3'b010, 32'h80000004, 32'h12345678, 1, 32'h80000004, 32'h12345678, 4'b1111, 0, 0, 3);
        run(0, 3'b111, 32'h80000000, 0, 0, 0, 0, 0, 0, 1, 1);
        run(0, 3'b011, 32'h80000000, 0, 0, 0, 0, 0, 0, 1, 1);
        run(0, 3'b110, 32'h80000000, 0, 0, 0, 0, 0, 0, 1, 1);
        run(1, 3'b100, 32'h80000000, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        run(0, 3'b010, 32'h80000001, 0, 0, 0, 0, 0, 0, 1, 1);
        run(0, 3'b001, 32'h80000003, 0, 0, 0, 0, 0, 0, 1, 1);
        run(1, 3'b010, 32'h80000002, 32'h11223344, 0, 0, 0, 0, 0, 1, 1);
`else
        run(0, 3'b010, 32'h80000001, 0, 1, 32'h80000000, 0, 0, 32'h80FF1234, 0, 3);
        run(0, 3'b001, 32'h80000003, 0, 1, 32'h80000000, 0, 0, 32'hFFFF80FF, 0, 3);
        run(1, 3'b010, 32'h80000002, 32'h11223344, 1, 32'h80000000, 32'h11223344, 4'b1111, 0, 0, 3);
`endif

        bus_rerr = 1;
        run(0, 3'b010, 32'h80000000, 0, 1, 32'h80000000, 0, 0, 0, 1, 3);
        bus_rerr = 0;

        // Response back-pressure: result held, next operation waits for the handshake.
        @(posedge clk); #1 ordy = 0;
        b.a = 32'h80000000; b.we = 0; b.wd = 0; b.st = 0; b.cs = 0;
        bq.push_back(b);
        issue(0, 3'b100, 32'h80000003, 0, 64'h80, 0, -1, 1, acc);
        for (int i = 0; i < 20 && !ov; i++) @(negedge clk);
        chk("stall_reached_resp", ov, 1);
        repeat (5) begin
            @(negedge clk);
            v = 1; wen = 0; f3 = 3'b010; addr = 32'h80000000; wdata = 0;
            chk("stall_out_valid", ov, 1);
            chk("stall_out_rdata", ordata, 32'h00000080);
            chk("stall_in_ready", rdy, 0);
        end
        bq.push_back(b);
        @(posedge clk); #1 ordy = 1;
        rc = cyc;
        issue(0, 3'b010, 32'h80000000, 0, 64'h80FF1234, 0, 3, 1, acc2);
        chk("accept_after_handshake", acc2, rc + 1);
        drain();

        gnt_en = 0;
        r0 = reqcyc;
        issue(0, 3'b010, 32'h80000010, 0, 0, 1, 5, 1, acc);
        drain();
        chk("timeout_req_cycles", reqcyc - r0, 4);
        gnt_en = 1;
        stray_pulse();

        // Reset while waiting for the read response.
        rv_en = 0;
        b.a = 32'h80000008;
        bq.push_back(b);
        issue(0, 3'b010, 32'h80000008, 0, 0, 0, 0, 0, acc);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("rst_in_ready", rdy, 0);
        chk_idle_outputs("rst");
        rst = 0;
        @(negedge clk);
        chk("rst_back_in_idle", rdy, 1);
        rv_en = 1;
        stray_pulse();

        issue64(3'b011, 32'h80000008, 32'h80000008, 64'hF123456789ABCDEF);
        issue64(3'b010, 32'h8000000C, 32'h80000008, 64'hFFFFFFFFF1234567);
        issue64(3'b110, 32'h8000000C, 32'h80000008, 64'h00000000F1234567);
        issue64(3'b000, 32'h8000000F, 32'h80000008, 64'hFFFFFFFFFFFFFFF1);

        chk("bus_queue_empty", bq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
